// File: rtl/sprite_drawer_pkg.sv
// Shared constants and types for the sprite drawer.
// Screen geometry, colour width, sprite defaults and FSM states.
package sprite_drawer_pkg;

    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;
    localparam int COLOUR_W = 9;

    localparam int SPR_W_DEF = 8;
    localparam int SPR_H_DEF = 8;

    localparam logic [COLOUR_W-1:0] TRANSPARENT_DEF = 9'h1C7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BG_RUN,
        S_CHAR_RUN,
        S_FLUSH,
        S_DONE,
        S_RELEASE
    } state_e;

    // y*320 + x as shift-add: y*256 + y*64 + x
    function automatic logic [16:0] screen_addr(
        input logic [8:0] y,
        input logic [9:0] x
    );
        logic [16:0] yy;
        yy = {8'd0, y};
        return (yy << 8) + (yy << 6) + {7'd0, x};
    endfunction

endpackage

// File: rtl/sprite_drawer_if.sv
// Request, ROM and VGA signals of the sprite drawer.
// master = drawer side, slave = surrounding system.
interface sprite_drawer_if;
    import sprite_drawer_pkg::*;

    logic                drawBG;
    logic                drawChar;
    logic [8:0]          xCoordinate;
    logic [7:0]          yCoordinate;
    logic [16:0]         bgAddr;
    logic [COLOUR_W-1:0] bgData;
    logic [5:0]          charAddr;
    logic [COLOUR_W-1:0] charData;
    logic [8:0]          vgaX;
    logic [7:0]          vgaY;
    logic [COLOUR_W-1:0] vgaColour;
    logic                plot;
    logic                doneBG;
    logic                doneChar;

    modport master (
        input  drawBG, drawChar, xCoordinate, yCoordinate,
        input  bgData, charData,
        output bgAddr, charAddr,
        output vgaX, vgaY, vgaColour, plot,
        output doneBG, doneChar
    );

    modport slave (
        output drawBG, drawChar, xCoordinate, yCoordinate,
        output bgData, charData,
        input  bgAddr, charAddr,
        input  vgaX, vgaY, vgaColour, plot,
        input  doneBG, doneChar
    );

endinterface

// File: rtl/pixel_scan_counter.sv
// Column/row raster counter over the sprite box.
// Column is the inner loop; last_o flags the final pixel.
module pixel_scan_counter #(
    parameter int W = 8,
    parameter int H = 8,
    localparam int CW = (W > 1) ? $clog2(W) : 1,
    localparam int RW = (H > 1) ? $clog2(H) : 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [CW-1:0] col_o,
    output logic [RW-1:0] row_o,
    output logic          last_o
);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          col_end, row_end;

    assign col_end = (col_q == CW'(W - 1));
    assign row_end = (row_q == RW'(H - 1));

    // Advance column, wrap into the next row, wrap at the end
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clr_i) begin
            col_d = '0;
            row_d = '0;
        end else if (en_i) begin
            if (col_end) begin
                col_d = '0;
                row_d = row_end ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col_o  = col_q;
    assign row_o  = row_q;
    assign last_o = col_end && row_end;

endmodule

// File: rtl/sprite_drawer.sv
// Sprite drawer: restores background or draws a character
// sprite into the VGA adapter, one pixel per cycle.
module sprite_drawer
    import sprite_drawer_pkg::*;
#(
    parameter int                  SPR_W       = SPR_W_DEF,
    parameter int                  SPR_H       = SPR_H_DEF,
    parameter logic [COLOUR_W-1:0] TRANSPARENT = TRANSPARENT_DEF
) (
    input logic             clock,
    input logic             resetn,
    sprite_drawer_if.master bus
);

    localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

    state_e state_q, state_d;

    logic [8:0]          x_q;
    logic [7:0]          y_q;
    logic                bg_q;
    logic [CW-1:0]       col;
    logic [RW-1:0]       row;
    logic                last;
    logic                run;
    logic                accept;
    logic                cnt_clr;
    logic                cnt_en;
    logic                done_bg_d;
    logic                done_ch_d;
    logic [9:0]          sx;
    logic [8:0]          sy;
    logic                on_screen;
    logic [16:0]         bg_addr_d;
    logic [5:0]          char_addr_d;

    logic                v1_q;
    logic                bg1_q;
    logic                on1_q;
    logic [8:0]          px1_q;
    logic [7:0]          py1_q;

    logic                plot_q;
    logic [8:0]          vx_q;
    logic [7:0]          vy_q;
    logic [COLOUR_W-1:0] vc_q;
    logic                done_bg_q;
    logic                done_ch_q;

    assign run    = (state_q == S_BG_RUN) || (state_q == S_CHAR_RUN);
    assign accept = (state_q == S_IDLE) && (bus.drawBG || bus.drawChar);

    // Sums are one bit wider so off-screen pixels never alias
    assign sx        = {1'b0, x_q} + 10'(col);
    assign sy        = {1'b0, y_q} + 9'(row);
    assign on_screen = (sx < 10'(SCREEN_W)) && (sy < 9'(SCREEN_H));

    pixel_scan_counter #(
        .W (SPR_W),
        .H (SPR_H)
    ) u_scan (
        .clk_i  (clock),
        .rst_ni (resetn),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .col_o  (col),
        .row_o  (row),
        .last_o (last)
    );

    // FSM state register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // FSM next state; background wins when both requests are up
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.drawBG)        state_d = S_BG_RUN;
                else if (bus.drawChar) state_d = S_CHAR_RUN;
            end
            S_BG_RUN, S_CHAR_RUN: begin
                if (last) state_d = S_FLUSH;
            end
            S_FLUSH: state_d = S_DONE;
            S_DONE:  state_d = S_RELEASE;
            S_RELEASE: begin
                if (bg_q ? !bus.drawBG : !bus.drawChar)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: counter control, ROM addresses, done requests
    always_comb begin
        cnt_clr     = (state_q == S_IDLE);
        cnt_en      = run;
        bg_addr_d   = '0;
        char_addr_d = '0;
        if (state_q == S_BG_RUN)
            bg_addr_d = screen_addr(sy, sx);
        if (state_q == S_CHAR_RUN)
            char_addr_d = 6'(int'(row) * SPR_W + int'(col));
        done_bg_d = (state_q == S_DONE) && bg_q;
        done_ch_d = (state_q == S_DONE) && !bg_q;
    end

    // Job latch, one-cycle ROM-aligned delay, registered pixel out
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            x_q       <= '0;
            y_q       <= '0;
            bg_q      <= 1'b0;
            v1_q      <= 1'b0;
            bg1_q     <= 1'b0;
            on1_q     <= 1'b0;
            px1_q     <= '0;
            py1_q     <= '0;
            plot_q    <= 1'b0;
            vx_q      <= '0;
            vy_q      <= '0;
            vc_q      <= '0;
            done_bg_q <= 1'b0;
            done_ch_q <= 1'b0;
        end else begin
            if (accept) begin
                x_q  <= bus.xCoordinate;
                y_q  <= bus.yCoordinate;
                bg_q <= bus.drawBG;
            end
            v1_q      <= run;
            bg1_q     <= (state_q == S_BG_RUN);
            on1_q     <= on_screen;
            px1_q     <= sx[8:0];
            py1_q     <= sy[7:0];
            plot_q    <= v1_q && on1_q &&
                         (bg1_q || (bus.charData != TRANSPARENT));
            vx_q      <= px1_q;
            vy_q      <= py1_q;
            vc_q      <= bg1_q ? bus.bgData : bus.charData;
            done_bg_q <= done_bg_d;
            done_ch_q <= done_ch_d;
        end
    end

    assign bus.bgAddr    = bg_addr_d;
    assign bus.charAddr  = char_addr_d;
    assign bus.plot      = plot_q;
    assign bus.vgaX      = vx_q;
    assign bus.vgaY      = vy_q;
    assign bus.vgaColour = vc_q;
    assign bus.doneBG    = done_bg_q;
    assign bus.doneChar  = done_ch_q;

endmodule

// File: tb/tb_sprite_drawer.sv
// Testbench for sprite_drawer: directed jobs against a
// per-cycle behavioural model of the pixel stream.
module tb_sprite_drawer;
    import sprite_drawer_pkg::*;

    localparam int          W  = 8;
    localparam int          H  = 8;
    localparam int          N  = W * H;
    localparam logic [8:0]  TR = 9'h1C7;

    logic clock  = 1'b0;
    logic resetn = 1'b0;

    sprite_drawer_if bus();

    sprite_drawer #(
        .SPR_W       (W),
        .SPR_H       (H),
        .TRANSPARENT (TR)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    logic [8:0] mem [N];

    // ROMs with one cycle of read latency
    always @(posedge clock) begin
        bus.bgData   <= bus.bgAddr[8:0];
        bus.charData <= mem[bus.charAddr];
    end

    int npass  = 0;
    int ntot   = 0;
    int cyc    = 0;
    int nplot  = 0;
    int ndone  = 0;
    int done_k = -1;

    bit m_on    = 1'b0;
    bit m_bg    = 1'b0;
    int m_x     = 0;
    int m_y     = 0;
    int m_start = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string nm, input int got, input int want);
        ntot++;
        if (got == want) npass++;
        else $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, got, want, $time);
    endtask

    // Model: k edges after the request is sampled, pixel k-2 is
    // on the VGA port, address k is on the ROM, done at k=N+2.
    always @(negedge clock) begin : cmp
        int k, c, r, sx, sy, ec;
        bit ep, eb, ed;
        k  = cyc - m_start;
        ep = 1'b0;
        ec = 0;
        sx = 0;
        sy = 0;
        if (m_on && k >= 2 && k < N + 2) begin
            c  = (k - 2) % W;
            r  = (k - 2) / W;
            sx = m_x + c;
            sy = m_y + r;
            ec = m_bg ? (sy * 320 + sx) % 512 : int'(mem[r * W + c]);
            ep = (sx < 320) && (sy < 240) && (m_bg || ec != int'(TR));
        end
        check("plot", int'(bus.plot), int'(ep));
        if (ep) begin
            check("vgaX", int'(bus.vgaX), sx);
            check("vgaY", int'(bus.vgaY), sy);
            check("vgaColour", int'(bus.vgaColour), ec);
        end
        eb = m_on && m_bg && (k == N + 2);
        ed = m_on && !m_bg && (k == N + 2);
        check("doneBG", int'(bus.doneBG), int'(eb));
        check("doneChar", int'(bus.doneChar), int'(ed));
        if (m_on && k >= 0 && k < N) begin
            c = k % W;
            r = k / W;
            if (m_bg) check("bgAddr", int'(bus.bgAddr), (m_y + r) * 320 + m_x + c);
            else      check("charAddr", int'(bus.charAddr), r * W + c);
        end
        if (bus.plot) nplot++;
        if (bus.doneBG || bus.doneChar) begin
            ndone++;
            done_k = k;
        end
    end

    task automatic start_job(input bit bg, input bit ch, input int x, input int y);
        bus.drawBG      = bg;
        bus.drawChar    = ch;
        bus.xCoordinate = 9'(x);
        bus.yCoordinate = 8'(y);
        m_bg    = bg;
        m_x     = x;
        m_y     = y;
        m_start = cyc + 1;
        m_on    = 1'b1;
        nplot   = 0;
        ndone   = 0;
        done_k  = -1;
    endtask

    task automatic finish_job(input string nm, input int plots, input int waited);
        repeat (N + 4 - waited) @(negedge clock);
        check({nm, " plots"}, nplot, plots);
        check({nm, " done cycle"}, done_k, N + 2);
        check({nm, " done pulses"}, ndone, 1);
    endtask

    initial begin
        bus.drawBG      = 1'b0;
        bus.drawChar    = 1'b0;
        bus.xCoordinate = '0;
        bus.yCoordinate = '0;
        for (int i = 0; i < N; i++) mem[i] = 9'h0F0;
        mem[0] = TR;

        repeat (3) @(negedge clock);
        check("rst plot", int'(bus.plot), 0);
        check("rst doneBG", int'(bus.doneBG), 0);
        check("rst doneChar", int'(bus.doneChar), 0);
        check("rst vgaX", int'(bus.vgaX), 0);
        check("rst vgaY", int'(bus.vgaY), 0);
        check("rst vgaColour", int'(bus.vgaColour), 0);
        check("rst bgAddr", int'(bus.bgAddr), 0);
        check("rst charAddr", int'(bus.charAddr), 0);
        resetn = 1'b1;
        @(negedge clock);

        // Background at (100,50): first pixel addr 16100 -> colour 228
        start_job(1'b1, 1'b0, 100, 50);
        repeat (3) @(negedge clock);
        check("bg first plot", int'(bus.plot), 1);
        check("bg first x", int'(bus.vgaX), 100);
        check("bg first y", int'(bus.vgaY), 50);
        check("bg first colour", int'(bus.vgaColour), 228);
        finish_job("bg", 64, 3);
        bus.drawBG = 1'b0;
        @(negedge clock);

        // Character at (95,221) with a transparent top-left pixel
        start_job(1'b0, 1'b1, 95, 221);
        finish_job("char", 63, 0);
        bus.drawChar = 1'b0;
        @(negedge clock);

        // Both requests: background first, char after drawBG drops
        start_job(1'b1, 1'b1, 10, 20);
        finish_job("both bg", 64, 0);
        bus.drawBG = 1'b0;
        m_bg    = 1'b0;
        m_start = cyc + 2;
        nplot   = 0;
        ndone   = 0;
        done_k  = -1;
        repeat (N + 5) @(negedge clock);
        check("both char plots", nplot, 63);
        check("both char done cycle", done_k, N + 2);
        check("both char done pulses", ndone, 1);
        bus.drawChar = 1'b0;
        @(negedge clock);

        // Clipping at (316,236): 4x4 visible, addr 75836 -> colour 60
        start_job(1'b1, 1'b0, 316, 236);
        repeat (3) @(negedge clock);
        check("clip first x", int'(bus.vgaX), 316);
        check("clip first y", int'(bus.vgaY), 236);
        check("clip first colour", int'(bus.vgaColour), 60);
        finish_job("clip", 16, 3);
        bus.drawBG = 1'b0;
        @(negedge clock);

        // Held request must not retrigger; a fresh edge does
        start_job(1'b1, 1'b0, 0, 0);
        finish_job("hold", 64, 0);
        repeat (10) @(negedge clock);
        check("hold done pulses", ndone, 1);
        check("hold plots", nplot, 64);
        bus.drawBG = 1'b0;
        @(negedge clock);
        start_job(1'b1, 1'b0, 0, 0);
        finish_job("retrigger", 64, 0);
        bus.drawBG = 1'b0;
        @(negedge clock);

        // Reset in the middle of a character job
        for (int i = 0; i < N; i++) mem[i] = 9'(i * 7 + 1);
        start_job(1'b0, 1'b1, 200, 100);
        repeat (21) @(negedge clock);
        #1;
        check("abort plots before reset", nplot, 19);
        #1;
        resetn = 1'b0;
        m_on   = 1'b0;
        #1;
        check("abort plot", int'(bus.plot), 0);
        check("abort vgaX", int'(bus.vgaX), 0);
        check("abort vgaColour", int'(bus.vgaColour), 0);
        check("abort charAddr", int'(bus.charAddr), 0);
        check("abort doneChar", int'(bus.doneChar), 0);
        repeat (3) @(negedge clock);
        check("abort done pulses", ndone, 0);
        #2;
        resetn  = 1'b1;
        m_on    = 1'b1;
        m_bg    = 1'b0;
        m_x     = 200;
        m_y     = 100;
        m_start = cyc + 1;
        nplot   = 0;
        ndone   = 0;
        done_k  = -1;
        finish_job("after reset", 64, 0);
        bus.drawChar = 1'b0;
        repeat (2) @(negedge clock);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
